piso_frame_arbiter: RTL and testbench

- Controller and 2-way round-robin arbiter in front of the 8-bit parallel-in/serial-out shift register.
- Accepts words from two requesters over a Req/Ack handshake and latches the granted word.
- Drives the shift register's load/shift-bar control and parallel data inputs, and counts the shift cycles of each frame.
- Reports frame busy, per-bit valid and per-requester done so upstream logic never overruns the shared serializer.

---
 rtl/piso_frame_arbiter.sv | 171 +++++++++++++++++
 tb/tb_piso_frame_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_frame_arbiter.sv
// piso_frame_arbiter
//   Two-requester round-robin front end for an 8-bit parallel-in/serial-out
//   shift register. A granted word is latched, loaded into the shift register
//   for one cycle, then shifted out LSB first over DATA_WIDTH cycles. An
//   optional idle gap separates frames. Every output is a register, so no
//   combinational path runs from Req_In to any output.
//
// Ports
//   Clk_In           clock; controller acts on posedge, shift register on negedge
//   Reset_In         asynchronous active-high reset (shared with shift register)
//   Req_In[1:0]      level requests; data must be held until the matching Ack
//   Data0_In         requester 0 word
//   Data1_In         requester 1 word
//   Ack_Out[1:0]     one-cycle pulse in LOAD: word captured
//   Done_Out[1:0]    one-cycle pulse on the last shift cycle of the owner's frame
//   Busy_Out         high in LOAD, SHIFT and GAP
//   Load_Shiftb_Out  shift register load (1) / shift (0) select
//   Piso_Data_Out    latched word, drives the shift register parallel input
//   Bit_Valid_Out    high in each SHIFT cycle
//   Bit_Index_Out    index of the bit emitted this SHIFT cycle (0 = LSB)
module piso_frame_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [1:0]            Req_In,
  input  logic [DATA_WIDTH-1:0] Data0_In,
  input  logic [DATA_WIDTH-1:0] Data1_In,
  output logic [1:0]            Ack_Out,
  output logic [1:0]            Done_Out,
  output logic                  Busy_Out,
  output logic                  Load_Shiftb_Out,
  output logic [DATA_WIDTH-1:0] Piso_Data_Out,
  output logic                  Bit_Valid_Out,
  output logic [2:0]            Bit_Index_Out
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic [CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             any_req;
  logic             pick;

  function automatic logic [1:0] onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

  // Round-robin choice: a lone requester always wins; on a tie the
  // requester that did not win last time is chosen.
  always_comb begin
    any_req = |Req_In;
    pick    = 1'b0;
    case (Req_In)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = 1'b0;
    endcase
  end

  // Controller state and all registered outputs
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      grant           <= 1'b0;
      bit_cnt         <= '0;
      gap_cnt         <= '0;
      Ack_Out         <= 2'b00;
      Done_Out        <= 2'b00;
      Busy_Out        <= 1'b0;
      Load_Shiftb_Out <= 1'b0;
      Piso_Data_Out   <= '0;
      Bit_Valid_Out   <= 1'b0;
      Bit_Index_Out   <= 3'd0;
    end else begin
      // Pulses and per-bit outputs drop unless the branch below re-asserts them.
      Ack_Out         <= 2'b00;
      Done_Out        <= 2'b00;
      Load_Shiftb_Out <= 1'b0;
      Bit_Valid_Out   <= 1'b0;
      Bit_Index_Out   <= 3'd0;

      case (state)
        IDLE: begin
          Busy_Out <= 1'b0;
          if (any_req) begin
            Piso_Data_Out   <= pick ? Data1_In : Data0_In;
            last_grant      <= pick;
            grant           <= pick;
            Ack_Out         <= onehot(pick);
            Load_Shiftb_Out <= 1'b1;
            Busy_Out        <= 1'b1;
            state           <= LOAD;
          end
        end

        LOAD: begin
          bit_cnt       <= '0;
          Bit_Valid_Out <= 1'b1;
          Bit_Index_Out <= 3'd0;
          Busy_Out      <= 1'b1;
          // A one-bit word finishes on its very first shift cycle.
          Done_Out      <= (LAST_BIT == '0) ? onehot(grant) : 2'b00;
          state         <= SHIFT;
        end

        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt  <= '0;
              Busy_Out <= 1'b1;
              state    <= GAP;
            end else begin
              Busy_Out <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            bit_cnt       <= bit_cnt + 1'b1;
            Bit_Valid_Out <= 1'b1;
            Bit_Index_Out <= 3'(bit_cnt + 1'b1);
            Busy_Out      <= 1'b1;
            if ((bit_cnt + 1'b1) == LAST_BIT) begin
              Done_Out <= onehot(grant);
            end
          end
        end

        GAP: begin
          // Requests are ignored here; they are picked up in the next IDLE.
          if (gap_cnt == LAST_GAP) begin
            Busy_Out <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          Busy_Out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Protocol checker: a requester holding Req must keep its word stable
  // until it has seen its Ack.
  data0_hold_chk: assert property (@(posedge Clk_In) disable iff (Reset_In)
    ($past(Req_In[0]) && Req_In[0] && !$past(Ack_Out[0])) |-> (Data0_In == $past(Data0_In)));

  data1_hold_chk: assert property (@(posedge Clk_In) disable iff (Reset_In)
    ($past(Req_In[1]) && Req_In[1] && !$past(Ack_Out[1])) |-> (Data1_In == $past(Data1_In)));

endmodule

// File: tb/tb_piso_frame_arbiter.sv
// Bench for piso_frame_arbiter: default instance (GAP_CYCLES=1) with a model
// of the negedge shift register, plus a GAP_CYCLES=0 instance.
module tb_piso_frame_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] d0, d1;
  logic [1:0] ack, done;
  logic       busy, load, valid;
  logic [7:0] piso;
  logic [2:0] idx;

  logic [1:0] g0_req;
  logic [7:0] g0_d0, g0_d1;
  logic [1:0] g0_ack, g0_done;
  logic       g0_busy, g0_load, g0_valid;
  logic [7:0] g0_piso;
  logic [2:0] g0_idx;

  always #5 clk = ~clk;

  piso_frame_arbiter #(.DATA_WIDTH(8), .GAP_CYCLES(1)) dut (
    .Clk_In(clk), .Reset_In(rst), .Req_In(req), .Data0_In(d0), .Data1_In(d1),
    .Ack_Out(ack), .Done_Out(done), .Busy_Out(busy), .Load_Shiftb_Out(load),
    .Piso_Data_Out(piso), .Bit_Valid_Out(valid), .Bit_Index_Out(idx)
  );

  piso_frame_arbiter #(.DATA_WIDTH(8), .GAP_CYCLES(0)) dut_g0 (
    .Clk_In(clk), .Reset_In(rst), .Req_In(g0_req), .Data0_In(g0_d0), .Data1_In(g0_d1),
    .Ack_Out(g0_ack), .Done_Out(g0_done), .Busy_Out(g0_busy), .Load_Shiftb_Out(g0_load),
    .Piso_Data_Out(g0_piso), .Bit_Valid_Out(g0_valid), .Bit_Index_Out(g0_idx)
  );

  // Shift register model: loads on negedge when Load is high, otherwise
  // shifts LSB out and a 1 in.
  logic [7:0] sr;
  logic       ser;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      sr  <= 8'hFF;
      ser <= 1'b1;
    end else if (load) begin
      sr <= piso;
    end else begin
      ser <= sr[0];
      sr  <= {1'b1, sr[7:1]};
    end
  end

  typedef struct {
    logic       id;
    logic [7:0] word;
  } frame_t;

  frame_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, want);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: event not seen within bound (got none, required one)", name);
  endtask

  function automatic logic [1:0] oh(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ack != 2'b00) begin seen = 1'b1; break; end
      tick;
    end
    if (!seen) fail_now(name);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done != 2'b00) begin seen = 1'b1; break; end
      tick;
    end
    if (!seen) fail_now(name);
  endtask

  task automatic wait_idle(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) begin seen = 1'b1; break; end
      tick;
    end
    if (!seen) fail_now(name);
  endtask

  // Scoreboard monitor: pops the expected frame on each Ack and checks
  // every emitted bit, its index and the Done pulse.
  logic   mon_active = 1'b0;
  frame_t mon_cur;
  int     mon_idx = 0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (ack != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL mon_ack: got ack %0b, required no ack (queue empty)", ack);
        end else begin
          mon_cur = exp_q.pop_front();
          check("mon_ack_id", 32'(ack), 32'(oh(mon_cur.id)));
          check("mon_load", 32'(load), 32'd1);
          check("mon_piso", 32'(piso), 32'(mon_cur.word));
          mon_active = 1'b1;
          mon_idx    = 0;
        end
      end
      if (valid) begin
        if (!mon_active) begin
          n_total++;
          $display("FAIL mon_valid: got bit_valid 1, required 0 (no frame)");
        end else begin
          check("mon_bit_index", 32'(idx), 32'(mon_idx));
          check("mon_serial", 32'(ser), 32'(mon_cur.word[mon_idx]));
          check("mon_done", 32'(done), (mon_idx == 7) ? 32'(oh(mon_cur.id)) : 32'd0);
          if (mon_idx == 7) mon_active = 1'b0;
          mon_idx++;
        end
      end else if (done != 2'b00) begin
        n_total++;
        $display("FAIL mon_stray_done: got done %0b, required 00", done);
      end
    end
  end

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_id;
    logic [7:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int last_c;
    int n_ack;
    bit seen;

    // Order matters: last_grant carries over between rows.
    vecs[0] = '{2'b01, 8'h3C, 8'h00, 1'b0, 8'h3C};
    vecs[1] = '{2'b10, 8'h00, 8'hC3, 1'b1, 8'hC3};
    vecs[2] = '{2'b11, 8'h55, 8'hAA, 1'b0, 8'h55};
    vecs[3] = '{2'b11, 8'h81, 8'h7E, 1'b1, 8'h7E};
    vecs[4] = '{2'b10, 8'h00, 8'hFF, 1'b1, 8'hFF};
    vecs[5] = '{2'b11, 8'h12, 8'h34, 1'b0, 8'h12};

    rst = 1'b1; req = 2'b00; d0 = 8'h00; d1 = 8'h00;
    g0_req = 2'b00; g0_d0 = 8'h00; g0_d1 = 8'h00;
    tick; tick;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_piso", 32'(piso), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_index", 32'(idx), 32'd0);
    rst = 1'b0;
    tick;

    // Single frame of A5 with exact latency
    d0 = 8'hA5; req = 2'b01;
    exp_q.push_back('{1'b0, 8'hA5});
    tick;
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_load", 32'(load), 32'd1);
    check("t1_piso", 32'(piso), 32'hA5);
    check("t1_busy", 32'(busy), 32'd1);
    req = 2'b00; d0 = 8'h00;
    tick;
    check("t1_valid0", 32'(valid), 32'd1);
    check("t1_index0", 32'(idx), 32'd0);
    check("t1_ack_clear", 32'(ack), 32'd0);
    check("t1_load_clear", 32'(load), 32'd0);
    repeat (7) tick;
    check("t1_index7", 32'(idx), 32'd7);
    check("t1_done", 32'(done), 32'h1);
    tick;
    check("t1_gap_valid", 32'(valid), 32'd0);
    check("t1_gap_busy", 32'(busy), 32'd1);
    check("t1_gap_done", 32'(done), 32'd0);
    tick;
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      d0 = vecs[i].d0; d1 = vecs[i].d1; req = vecs[i].req;
      exp_q.push_back('{vecs[i].exp_id, vecs[i].exp_word});
      wait_ack("tbl_ack_wait");
      check("tbl_ack_id", 32'(ack), 32'(oh(vecs[i].exp_id)));
      req = 2'b00;
      wait_done("tbl_done_wait");
      wait_idle("tbl_idle_wait");
    end

    // Fairness from reset: both held, grants 0,1,0,1 spaced 11 cycles
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    d0 = 8'h0F; d1 = 8'hF0; req = 2'b11;
    exp_q.push_back('{1'b0, 8'h0F});
    exp_q.push_back('{1'b1, 8'hF0});
    exp_q.push_back('{1'b0, 8'h0F});
    exp_q.push_back('{1'b1, 8'hF0});
    last_c = 0; n_ack = 0;
    for (int c = 0; c < 100 && n_ack < 4; c++) begin
      tick;
      if (ack != 2'b00) begin
        if (n_ack > 0) check("fair_spacing", 32'(c - last_c), 32'd11);
        last_c = c;
        n_ack++;
      end
    end
    if (n_ack < 4) fail_now("fair_acks");
    req = 2'b00;
    wait_done("fair_done_wait");
    wait_idle("fair_idle_wait");

    // Reset in the middle of SHIFT
    d0 = 8'h99; req = 2'b01;
    exp_q.push_back('{1'b0, 8'h99});
    wait_ack("mid_ack_wait");
    req = 2'b00;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (valid && idx == 3'd3) begin seen = 1'b1; break; end
      tick;
    end
    if (!seen) fail_now("mid_index3_wait");
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_index", 32'(idx), 32'd0);
    check("mid_rst_piso", 32'(piso), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    tick;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      check("mid_no_done", 32'(done), 32'd0);
    end
    d0 = 8'h66; d1 = 8'h77; req = 2'b11;
    exp_q.push_back('{1'b0, 8'h66});
    wait_ack("mid_regrant_wait");
    check("mid_regrant_id", 32'(ack), 32'h1);
    req = 2'b00;
    wait_done("mid_done_wait");
    wait_idle("mid_idle_wait");

    // Idle line after a frame of zeros
    d0 = 8'h00; req = 2'b01;
    exp_q.push_back('{1'b0, 8'h00});
    wait_ack("idle_ack_wait");
    req = 2'b00;
    wait_done("idle_done_wait");
    wait_idle("idle_idle_wait");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(valid), 32'd0);
      check("idle_load", 32'(load), 32'd0);
      check("idle_serial", 32'(ser), 32'd1);
    end

    // Request arriving during GAP is held off until IDLE
    tick;
    d0 = 8'h5A; req = 2'b01;
    exp_q.push_back('{1'b0, 8'h5A});
    wait_ack("gap_ack_wait");
    req = 2'b00;
    wait_done("gap_done_wait");
    tick;
    check("gap_state_busy", 32'(busy), 32'd1);
    check("gap_state_valid", 32'(valid), 32'd0);
    d1 = 8'hB4; req = 2'b10;
    exp_q.push_back('{1'b1, 8'hB4});
    tick;
    check("gap_idle_busy", 32'(busy), 32'd0);
    check("gap_idle_ack", 32'(ack), 32'd0);
    tick;
    check("gap_late_ack", 32'(ack), 32'h2);
    check("gap_late_load", 32'(load), 32'd1);
    req = 2'b00;
    wait_done("gap_late_done_wait");
    wait_idle("gap_late_idle_wait");

    // GAP_CYCLES=0: back-to-back frames every 10 cycles
    g0_d1 = 8'hC5; g0_req = 2'b10;
    last_c = 0; n_ack = 0;
    for (int c = 0; c < 80 && n_ack < 3; c++) begin
      tick;
      if (g0_ack != 2'b00) begin
        check("g0_ack_id", 32'(g0_ack), 32'h2);
        check("g0_piso", 32'(g0_piso), 32'hC5);
        if (n_ack > 0) check("g0_spacing", 32'(c - last_c), 32'd10);
        last_c = c;
        n_ack++;
      end
    end
    if (n_ack < 3) fail_now("g0_acks");
    g0_req = 2'b00;
    repeat (12) tick;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
